// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider, h/v timing counters and registered sync/colour output stage.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] graph_rgb,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        video_on,
  output logic        p_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX  = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_ON  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_OFF = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  logic [DW-1:0] div;
  logic h_end, v_end;
  always_comb begin
    p_tick     = div == DIV_MAX;
    h_end      = hcount == H_MAX;
    v_end      = vcount == V_MAX;
    video_on   = (hcount < H_VIS) && (vcount < V_VIS);
    frame_tick = p_tick && h_end && v_end;
  end
  // Output stage samples the pre-increment counters so sync and colour share one pixel of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      rgb    <= '0;
    end else begin
      div <= p_tick ? '0 : div + DW'(1);
      if (p_tick) begin
        hcount <= h_end ? '0 : hcount + 10'd1;
        if (h_end) vcount <= v_end ? '0 : vcount + 10'd1;
        hsync <= ~((hcount >= HS_ON) && (hcount < HS_OFF));
        vsync <= ~((vcount >= VS_ON) && (vcount < VS_OFF));
        rgb   <= video_on ? graph_rgb : 12'h000;
      end
    end
  end
endmodule
